instr_fetch_reg: RTL

// - Instruction register plus memory fetch sequencer for the 16-bit multicycle core.
// - On a control-unit request, it reads one 16-bit instruction word from memory through a ready handshake.
// - The word is held in IR until the next successful fetch.
// - It splits the held word into fields. imm8 feeds the 8->16 immediate extender directly downstream.
// - Bounded wait: flags a memory timeout instead of hanging.

---
 rtl/instr_fetch_reg_pkg.sv | 48 ++++
 rtl/instr_fetch_reg_if.sv | 30 +++
 rtl/instr_fetch_reg_fetch_timer.sv | 35 +++
 rtl/instr_fetch_reg.sv | 125 ++++++++++++
 4 files changed

// File: rtl/instr_fetch_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_reg_pkg
// Brief   : Shared field positions, FSM encoding and decode helper for fetch.
// Revision: 1.0 - initial release
// ============================================================================
package instr_fetch_reg_pkg;

  localparam int WORD_W = 16;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [3:0] NOP_OPCODE = 4'h0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [7:0] imm8;
  } instr_fields_t;

  function automatic instr_fields_t split_instr(input logic [WORD_W-1:0] w);
    instr_fields_t f;
    f.opcode = w[OPC_HI:OPC_LO];
    f.rd     = w[RD_HI:RD_LO];
    f.rs     = w[RS_HI:RS_LO];
    f.rt     = w[RT_HI:RT_LO];
    f.imm8   = w[IMM_HI:IMM_LO];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_reg_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_reg_if
// Brief   : Instruction memory read bus (strobe/address out, ready/data back).
// Revision: 1.0 - initial release
// ============================================================================
interface instr_fetch_reg_if;
  import instr_fetch_reg_pkg::*;

  logic              mem_rd;
  logic [WORD_W-1:0] mem_addr;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_data;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_ready,
    input  mem_data
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_ready,
    output mem_data
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_reg_fetch_timer.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_reg_fetch_timer
// Brief   : 8-bit saturating wait counter; done flags the last allowed cycle.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_reg_fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_done
);

  localparam logic [7:0] c_last = 8'(TIMEOUT - 1);
  localparam logic [7:0] c_max  = 8'hFF;

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en && (r_count != c_max)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_done = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_reg.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_reg
// Brief   : Instruction register with single-word memory fetch sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_reg
  import instr_fetch_reg_pkg::*;
#(
  parameter int                TIMEOUT = 16,
  parameter logic [WORD_W-1:0] RST_IR  = {NOP_OPCODE, 12'h000}
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              fetch_req,
  input  wire logic [WORD_W-1:0] pc_in,
  instr_fetch_reg_if.master      mem,
  output logic                   busy,
  output logic                   ir_load,
  output logic                   fetch_err,
  output logic [WORD_W-1:0]      ir_out,
  output logic [3:0]             opcode,
  output logic [3:0]             rd,
  output logic [3:0]             rs,
  output logic [3:0]             rt,
  output logic [7:0]             imm8
);

  fetch_state_t      r_state;
  fetch_state_t      w_next;
  logic              w_accept;
  logic              w_load;
  logic              w_abort;
  logic              w_in_wait;
  logic              w_tmr_done;
  logic [WORD_W-1:0] r_ir;
  logic [WORD_W-1:0] r_addr;
  logic              r_err;
  logic              r_load;
  instr_fields_t     w_fields;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A ready on the final allowed wait edge takes priority over the abort.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fetch_req) begin
          w_accept = 1'b1;
          w_next   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem.mem_ready) begin
          w_load = 1'b1;
          w_next = ST_IDLE;
        end else if (w_tmr_done) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir   <= RST_IR;
      r_addr <= '0;
      r_err  <= 1'b0;
      r_load <= 1'b0;
    end else begin
      r_load <= w_load;
      if (w_accept) begin
        r_addr <= pc_in;
        r_err  <= 1'b0;
      end
      if (w_load) begin
        r_ir <= mem.mem_data;
      end
      if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_in_wait = (r_state == ST_WAIT);

  instr_fetch_reg_fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_accept),
    .i_en   (w_in_wait && !mem.mem_ready),
    .o_done (w_tmr_done)
  );

  // Strobe is decoded from the state register so reset drops it at once.
  assign mem.mem_rd   = w_in_wait;
  assign mem.mem_addr = r_addr;
  assign busy         = w_in_wait;
  assign ir_load      = r_load;
  assign fetch_err    = r_err;
  assign ir_out       = r_ir;

  assign w_fields = split_instr(r_ir);
  assign opcode   = w_fields.opcode;
  assign rd       = w_fields.rd;
  assign rs       = w_fields.rs;
  assign rt       = w_fields.rt;
  assign imm8     = w_fields.imm8;

endmodule
`default_nettype wire
